// File: rtl/dc_token_ring_rd_stage.sv
// Read-side endpoint of a dual-clock token-ring channel: synchronises write tokens, streams words, returns read pointer.
// Optional output register enabled by defining DC_RD_STAGE_OUTREG_EN (default: combinational pass-through).
module dc_token_ring_rd_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [BUFFER_WIDTH-1:0] write_token,
    input  logic [DATA_WIDTH-1:0]   data_async,
    output logic [BUFFER_WIDTH-1:0] read_pointer,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    input  logic                    ready_i,
    output logic                    empty_o
);

    localparam int PTR_W = $clog2(BUFFER_WIDTH);
    localparam logic [PTR_W-1:0] LAST_POS = PTR_W'(BUFFER_WIDTH - 1);

    logic [BUFFER_WIDTH-1:0] wt_meta;
    logic [BUFFER_WIDTH-1:0] wt_sync;
    logic [BUFFER_WIDTH-1:0] rd_tog;
    logic [PTR_W-1:0]        rd_pos;
    logic                    avail;
    logic                    accept;
    logic                    pop;

    // Per-bit synchronisation is safe: each remote write flips exactly one token bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wt_meta <= '0;
            wt_sync <= '0;
        end else begin
            wt_meta <= write_token;
            wt_sync <= wt_meta;
        end
    end

    assign avail   = wt_sync[rd_pos] ^ rd_tog[rd_pos];
    assign pop     = avail && accept;
    assign empty_o = !avail;

    // rd_pos always equals the write side's mux index derived from read_pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_tog <= '0;
            rd_pos <= '0;
        end else if (pop) begin
            rd_tog[rd_pos] <= ~rd_tog[rd_pos];
            rd_pos         <= (rd_pos == LAST_POS) ? '0 : rd_pos + PTR_W'(1);
        end
    end

    assign read_pointer = rd_tog;

`ifdef DC_RD_STAGE_OUTREG_EN
    logic                  oreg_valid;
    logic [DATA_WIDTH-1:0] oreg_data;

    assign accept = !oreg_valid || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oreg_valid <= 1'b0;
            oreg_data  <= '0;
        end else if (pop) begin
            oreg_valid <= 1'b1;
            oreg_data  <= data_async;
        end else if (ready_i) begin
            oreg_valid <= 1'b0;
        end
    end

    assign valid_o = oreg_valid;
    assign data_o  = oreg_data;
`else
    assign accept  = ready_i;
    assign valid_o = avail;
    assign data_o  = data_async;
`endif

endmodule

// File: tb/tb_dc_token_ring_rd_stage.sv
// Directed bench for dc_token_ring_rd_stage (DATA_WIDTH=8, BUFFER_WIDTH=4); models the remote ring and its read mux.
// Honours DC_RD_STAGE_OUTREG_EN to shift expected latencies by one cycle.
module tb_dc_token_ring_rd_stage;

`ifdef DC_RD_STAGE_OUTREG_EN
    localparam int E = 1;
`else
    localparam int E = 0;
`endif

    logic       clk_i;
    logic       rst_ni;
    logic [3:0] write_token;
    logic [7:0] data_async;
    logic [3:0] read_pointer;
    logic       valid_o;
    logic [7:0] data_o;
    logic       ready_i;
    logic       empty_o;

    logic [7:0] mem [4];
    int n_cmp = 0;
    int n_err = 0;

    dc_token_ring_rd_stage #(.DATA_WIDTH(8), .BUFFER_WIDTH(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .write_token  (write_token),
        .data_async   (data_async),
        .read_pointer (read_pointer),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .ready_i      (ready_i),
        .empty_o      (empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Write-side mux: lowest i whose pointer bit differs from bit 0, else 0.
    function automatic int sel_slot(input logic [3:0] rp);
        for (int i = 1; i < 4; i++)
            if (rp[i] != rp[0]) return i;
        return 0;
    endfunction

    assign data_async = mem[sel_slot(read_pointer)];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        write_token = 4'b0000;
        ready_i     = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        ready_i     = 1'b0;
        write_token = 4'b0101;
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        mem[0] = 8'h77;

        // Reset state with tokens pending
        step();
        step();
        check("rst_valid", valid_o, 1'b0);
        check("rst_empty", empty_o, 1'b1);
        check("rst_rp", read_pointer, 4'b0000);
        check("rst_data", data_o, (E == 1) ? 8'h00 : 8'h77);
        rst_ni = 1'b1;
        step();
        check("rel_valid_e1", valid_o, 1'b0);
        repeat (1 + E) step();
        check("rel_valid_late", valid_o, 1'b1);
        check("rel_data", data_o, 8'h77);

        // Single word
        do_reset();
        mem[0]      = 8'hA5;
        ready_i     = 1'b1;
        write_token = 4'b0001;
        step();
        check("single_valid_e1", valid_o, 1'b0);
        repeat (1 + E) step();
        check("single_valid", valid_o, 1'b1);
        check("single_data", data_o, 8'hA5);
        step();
        check("single_rp", read_pointer, 4'b0001);
        check("single_valid_after", valid_o, 1'b0);
        check("single_empty", empty_o, 1'b1);

        // Full ring, back-to-back drain
        do_reset();
        mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h13;
        ready_i     = 1'b1;
        write_token = 4'b1111;
        repeat (2 + E) step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ring_valid%0d", i), valid_o, 1'b1);
            check($sformatf("ring_data%0d", i), data_o, 8'h10 + i);
            step();
        end
        check("ring_valid_end", valid_o, 1'b0);
        check("ring_rp", read_pointer, 4'b1111);

        // Wrap to slot 0
        mem[0]      = 8'h20;
        write_token = 4'b1110;
        repeat (2 + E) step();
        check("wrap_valid", valid_o, 1'b1);
        check("wrap_data", data_o, 8'h20);
        step();
        check("wrap_rp", read_pointer, 4'b1110);
        check("wrap_valid_end", valid_o, 1'b0);

        // Backpressure on slot 1
        mem[1]      = 8'h3C;
        ready_i     = 1'b0;
        write_token = 4'b1100;
        repeat (2 + E) step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), valid_o, 1'b1);
            check($sformatf("bp_data%0d", i), data_o, 8'h3C);
            check($sformatf("bp_rp%0d", i), read_pointer, (E == 1) ? 4'b1100 : 4'b1110);
            step();
        end
        ready_i = 1'b1;
        step();
        check("bp_pop_rp", read_pointer, 4'b1100);
        check("bp_pop_valid", valid_o, 1'b0);
        step();
        check("bp_once_rp", read_pointer, 4'b1100);
        check("bp_once_valid", valid_o, 1'b0);

        // Token toggle on the same edge as the slot-1 pop
        do_reset();
        mem[0] = 8'h40; mem[1] = 8'h41; mem[2] = 8'h42; mem[3] = 8'h00;
        ready_i     = 1'b1;
        write_token = 4'b0011;
        step();
        step();
        step();
        check("sim_valid_e3", valid_o, 1'b1);
        check("sim_data_e3", data_o, (E == 1) ? 8'h40 : 8'h41);
        write_token = 4'b0111;
        step();
        check("sim_rp_e4", read_pointer, 4'b0011);
        check("sim_valid_e4", valid_o, (E == 1) ? 1'b1 : 1'b0);
        step();
        check("sim_valid_e5", valid_o, (E == 1) ? 1'b0 : 1'b1);
        repeat (E) step();
        check("sim_data_slot2", data_o, 8'h42);
        check("sim_valid_slot2", valid_o, 1'b1);
        step();
        check("sim_rp_end", read_pointer, 4'b0111);
        check("sim_valid_end", valid_o, 1'b0);

        // Reset during a burst
        do_reset();
        mem[0] = 8'h50; mem[1] = 8'h51; mem[2] = 8'h52; mem[3] = 8'h53;
        ready_i     = 1'b1;
        write_token = 4'b1111;
        repeat (4) step();
        check("mid_rp_before", read_pointer, 4'b0011);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_valid", valid_o, 1'b0);
        check("mid_empty", empty_o, 1'b1);
        check("mid_rp", read_pointer, 4'b0000);
        check("mid_data", data_o, (E == 1) ? 8'h00 : 8'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
